// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong graphics block / score overlay and pong_game_ctrl.
// The rally member exists only when PONG_RALLY_CNT_EN is defined.
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       btn_start;
  logic       hit_a;
  logic       hit_b;
  logic       miss_a;
  logic       miss_b;
  logic       gra_still;
  logic [1:0] phase;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic       winner;
  logic       point_pulse;
`ifdef PONG_RALLY_CNT_EN
  logic [7:0] rally;
`endif

  modport master (
    output frame_tick, btn_start, hit_a, hit_b, miss_a, miss_b,
    input  gra_still, phase, score_a, score_b, winner, point_pulse
`ifdef PONG_RALLY_CNT_EN
    , input rally
`endif
  );

  modport slave (
    input  frame_tick, btn_start, hit_a, hit_b, miss_a, miss_b,
    output gra_still, phase, score_a, score_b, winner, point_pulse
`ifdef PONG_RALLY_CNT_EN
    , output rally
`endif
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game phase FSM: scores, serve delay, game-over hold and still control.
// Optional rally hit counter enabled by defining PONG_RALLY_CNT_EN.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned NEWBALL_FRAMES = 120,
  parameter int unsigned OVER_FRAMES    = 180,
  parameter int unsigned TIMER_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  gc
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } phase_t;

  phase_t               state;
  logic                 gra_still_q;
  logic [3:0]           score_a_q;
  logic [3:0]           score_b_q;
  logic                 winner_q;
  logic                 point_pulse_q;
  logic [TIMER_W-1:0]   timer;
  logic                 btn_start_d;
  logic                 frame_tick_d;
  logic                 start_rise_q;
  logic                 tick_rise_q;
  logic [3:0]           score_a_inc;
  logic [3:0]           score_b_inc;

`ifdef PONG_RALLY_CNT_EN
  logic                 hit_d;
  logic [7:0]           rally_q;
  logic                 hit_rise;
`endif

  always_comb begin
    score_a_inc = score_a_q + 4'd1;
    score_b_inc = score_b_q + 4'd1;
`ifdef PONG_RALLY_CNT_EN
    hit_rise    = (gc.hit_a | gc.hit_b) & ~hit_d;
`endif
  end

  // Edge pulses are registered, so a press sampled at edge N acts at edge N+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= NEWGAME;
      gra_still_q   <= 1'b1;
      score_a_q     <= '0;
      score_b_q     <= '0;
      winner_q      <= 1'b0;
      point_pulse_q <= 1'b0;
      timer         <= '0;
      btn_start_d   <= 1'b0;
      frame_tick_d  <= 1'b0;
      start_rise_q  <= 1'b0;
      tick_rise_q   <= 1'b0;
`ifdef PONG_RALLY_CNT_EN
      hit_d         <= 1'b0;
      rally_q       <= '0;
`endif
    end else begin
      btn_start_d   <= gc.btn_start;
      frame_tick_d  <= gc.frame_tick;
      start_rise_q  <= gc.btn_start & ~btn_start_d;
      tick_rise_q   <= gc.frame_tick & ~frame_tick_d;
      point_pulse_q <= 1'b0;
`ifdef PONG_RALLY_CNT_EN
      hit_d         <= gc.hit_a | gc.hit_b;
`endif

      case (state)
        NEWGAME: begin
          if (start_rise_q) begin
            score_a_q   <= '0;
            score_b_q   <= '0;
            state       <= PLAY;
            gra_still_q <= 1'b0;
`ifdef PONG_RALLY_CNT_EN
            rally_q     <= '0;
`endif
          end
        end

        PLAY: begin
          if (gc.miss_a || gc.miss_b) begin
            point_pulse_q <= 1'b1;
            gra_still_q   <= 1'b1;
            // miss_a takes priority: a simultaneous double miss scores once, for B.
            if (gc.miss_a) begin
              score_b_q <= score_b_inc;
              if (score_b_inc == 4'(WIN_SCORE)) begin
                state    <= OVER;
                winner_q <= 1'b0;
                timer    <= TIMER_W'(OVER_FRAMES);
              end else begin
                state    <= NEWBALL;
                timer    <= TIMER_W'(NEWBALL_FRAMES);
`ifdef PONG_RALLY_CNT_EN
                rally_q  <= '0;
`endif
              end
            end else begin
              score_a_q <= score_a_inc;
              if (score_a_inc == 4'(WIN_SCORE)) begin
                state    <= OVER;
                winner_q <= 1'b1;
                timer    <= TIMER_W'(OVER_FRAMES);
              end else begin
                state    <= NEWBALL;
                timer    <= TIMER_W'(NEWBALL_FRAMES);
`ifdef PONG_RALLY_CNT_EN
                rally_q  <= '0;
`endif
              end
            end
          end
`ifdef PONG_RALLY_CNT_EN
          else if (hit_rise && rally_q != 8'hFF) begin
            rally_q <= rally_q + 8'd1;
          end
`endif
        end

        NEWBALL: begin
          if (tick_rise_q) begin
            if (timer == '0) begin
              state       <= PLAY;
              gra_still_q <= 1'b0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end

        OVER: begin
          if (tick_rise_q) begin
            if (timer == '0) begin
              state <= NEWGAME;
            end else begin
              timer <= timer - 1'b1;
            end
          end
        end

        default: begin
          state       <= NEWGAME;
          gra_still_q <= 1'b1;
        end
      endcase
    end
  end

  assign gc.gra_still   = gra_still_q;
  assign gc.phase       = state;
  assign gc.score_a     = score_a_q;
  assign gc.score_b     = score_b_q;
  assign gc.winner      = winner_q;
  assign gc.point_pulse = point_pulse_q;
`ifdef PONG_RALLY_CNT_EN
  assign gc.rally       = rally_q;
`endif

endmodule
